// File: rtl/pc_sequencer.sv
// Registered fetch-stage program counter with RUN/HALTED control, stall hold and a circular return-address stack.
// Optional macro PC_ALIGN_CHECK_EN redirects misaligned targets to TRAP_VECTOR and pulses misalign.
module pc_sequencer #(
  parameter int INST_ADDR_WIDTH = 16,
  parameter int NUM_BYTES_IN_INST = 2,
  parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4,
  parameter logic [INST_ADDR_WIDTH-1:0] TRAP_VECTOR = 16'h0002
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic                       resume,
  input  logic                       stall,
  input  logic                       pc_src,
  input  logic                       call,
  input  logic                       ret,
  input  logic [INST_ADDR_WIDTH-1:0] branch_addr,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic                       halted,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_overflow,
  output logic                       ras_underflow,
  output logic                       misalign
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [INST_ADDR_WIDTH-1:0] INC = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                     state;
  logic [INST_ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [CNT_W-1:0]           count;

  logic [INST_ADDR_WIDTH-1:0] pc_inc;
  logic [INST_ADDR_WIDTH-1:0] pc_nxt;
  logic [INST_ADDR_WIDTH-1:0] target;
  logic [INST_ADDR_WIDTH-1:0] ras_top;
  logic [CNT_W-1:0]           cnt_nxt;
  logic                       push;
  logic                       pop;
  logic                       redirect;
  logic                       underflow_hit;
  logic                       mis_nxt;

  // Count saturates at RAS_DEPTH; a push while full overwrites the oldest slot instead.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

`ifdef PC_ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [INST_ADDR_WIDTH-1:0] a);
    return (32'(a) % NUM_BYTES_IN_INST) != 0;
  endfunction
`else
  logic [INST_ADDR_WIDTH-1:0] unused_trap_vector;
  assign unused_trap_vector = TRAP_VECTOR;
`endif

  assign ras_top = ras_mem[wr_ptr - PTR_W'(1)];

  always_comb begin
    pc_inc        = pc_out + INC;
    pc_nxt        = pc_out;
    target        = branch_addr;
    push          = 1'b0;
    pop           = 1'b0;
    redirect      = 1'b0;
    underflow_hit = 1'b0;
    mis_nxt       = 1'b0;
    if (state == RUN && !halt && !stall) begin
      if (call) begin
        push     = 1'b1;
        redirect = 1'b1;
      end else if (pc_src) begin
        redirect = 1'b1;
      end else if (ret && count != '0) begin
        pop      = 1'b1;
        redirect = 1'b1;
        target   = ras_top;
      end else begin
        pc_nxt        = pc_inc;
        underflow_hit = ret;
      end
    end
    if (redirect) begin
      pc_nxt = target;
`ifdef PC_ALIGN_CHECK_EN
      if (misaligned(target)) begin
        pc_nxt  = TRAP_VECTOR;
        mis_nxt = 1'b1;
      end
`endif
    end
    cnt_nxt = count;
    if (push)
      cnt_nxt = sat_inc(count);
    else if (pop)
      cnt_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      halted        <= 1'b0;
      pc_out        <= RESET_VECTOR;
      wr_ptr        <= '0;
      count         <= '0;
      ras_empty     <= 1'b1;
      ras_full      <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (resume) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
      pc_out    <= pc_nxt;
      misalign  <= mis_nxt;
      count     <= cnt_nxt;
      ras_empty <= (cnt_nxt == '0);
      ras_full  <= (cnt_nxt == CNT_MAX);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (count == CNT_MAX)
          ras_overflow <= 1'b1;
      end else if (pop) begin
        wr_ptr <= wr_ptr - PTR_W'(1);
      end
      if (underflow_hit)
        ras_underflow <= 1'b1;
    end
  end

  // Stack storage is pure data and is never reset; count guards every read.
  always_ff @(posedge clk) begin
    if (push)
      ras_mem[wr_ptr] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed sequences plus randomized control against a queue-based reference model.
module tb_pc_sequencer;

  localparam int W     = 16;
  localparam int INC   = 2;
  localparam int DEPTH = 4;
  localparam logic [W-1:0] RESET_VECTOR = 16'h0000;
  localparam logic [W-1:0] TRAP_VECTOR  = 16'h0002;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt = 1'b0, resume = 1'b0, stall = 1'b0, pc_src = 1'b0, call = 1'b0, ret = 1'b0;
  logic [W-1:0] branch_addr = '0;
  logic [W-1:0] pc_out;
  logic halted, ras_empty, ras_full, ras_overflow, ras_underflow, misalign;

  pc_sequencer #(
    .INST_ADDR_WIDTH(W), .NUM_BYTES_IN_INST(INC), .RESET_VECTOR(RESET_VECTOR),
    .RAS_DEPTH(DEPTH), .TRAP_VECTOR(TRAP_VECTOR)
  ) dut (
    .clk(clk), .rst(rst), .halt(halt), .resume(resume), .stall(stall),
    .pc_src(pc_src), .call(call), .ret(ret), .branch_addr(branch_addr),
    .pc_out(pc_out), .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] pc;
    logic halted;
    logic empty;
    logic full;
    logic ovf;
    logic unf;
    logic mis;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: the stack is a plain queue, oldest entry at the front.
  logic [W-1:0] m_pc = '0;
  logic         m_halted = 1'b0;
  logic         m_ovf = 1'b0, m_unf = 1'b0, m_mis = 1'b0;
  logic [W-1:0] m_ras[$];

  function automatic bit bad_align(input logic [W-1:0] a);
`ifdef PC_ALIGN_CHECK_EN
    return (a % INC) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_jump(input logic [W-1:0] t);
    if (bad_align(t)) begin
      m_pc  = TRAP_VECTOR;
      m_mis = 1'b1;
    end else begin
      m_pc = t;
    end
  endtask

  task automatic m_push(input logic [W-1:0] v);
    if (m_ras.size() == DEPTH) begin
      void'(m_ras.pop_front());
      m_ovf = 1'b1;
    end
    m_ras.push_back(v);
  endtask

  task automatic step(input bit r, input bit h, input bit rs, input bit st,
                      input bit ps, input bit cl, input bit rt, input logic [W-1:0] a);
    obs_t e;
    @(negedge clk);
    rst = ~r; halt = h; resume = rs; stall = st; pc_src = ps; call = cl; ret = rt; branch_addr = a;
    m_mis = 1'b0;
    if (r) begin
      m_pc = RESET_VECTOR; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
    end else if (m_halted) begin
      if (rs) m_halted = 1'b0;
    end else if (h) begin
      m_halted = 1'b1;
    end else if (st) begin
      // hold
    end else if (cl) begin
      m_push(m_pc + W'(INC));
      m_jump(a);
    end else if (ps) begin
      m_jump(a);
    end else if (rt && m_ras.size() > 0) begin
      m_jump(m_ras.pop_back());
    end else begin
      if (rt) m_unf = 1'b1;
      m_pc = m_pc + W'(INC);
    end
    e.pc = m_pc; e.halted = m_halted; e.empty = (m_ras.size() == 0);
    e.full = (m_ras.size() == DEPTH); e.ovf = m_ovf; e.unf = m_unf; e.mis = m_mis;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 16'h0000);
  endtask

  // Monitor: the DUT presents a new registered output every cycle.
  initial begin
    obs_t g, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{pc_out, halted, ras_empty, ras_full, ras_overflow, ras_underflow, misalign};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL vec%0d got pc=%h hlt=%b emp=%b full=%b ovf=%b unf=%b mis=%b expected pc=%h hlt=%b emp=%b full=%b ovf=%b unf=%b mis=%b",
                   vectors, g.pc, g.halted, g.empty, g.full, g.ovf, g.unf, g.mis,
                   e.pc, e.halted, e.empty, e.full, e.ovf, e.unf, e.mis);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired with %0d expected vectors pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    step(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    idle(3);
    idle(5);
    step(0, 0, 0, 0, 0, 1, 0, 16'h0100);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 1, 16'h0000);
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 0, 1, 0, W'(i * 16'h0100));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 0, 1, 0, 0, 16'h0020);
    step(0, 1, 0, 1, 0, 0, 0, 16'h0000);
    idle(2);
    step(0, 0, 1, 0, 0, 0, 0, 16'h0000);
    idle(2);
    step(0, 0, 1, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 1, 0, 0, 16'hFFFE);
    idle(2);
    step(0, 1, 0, 0, 0, 0, 0, 16'h0000);
    step(0, 1, 0, 0, 0, 1, 1, 16'h0040);
    step(1, 1, 0, 0, 0, 0, 0, 16'h0000);
    idle(1);
    step(0, 0, 0, 0, 1, 0, 0, 16'h0101);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0, 16'h0203);
    step(0, 0, 0, 0, 0, 0, 1, 16'h0000);
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] a;
      a = W'($urandom);
      if ($urandom_range(7) != 0) a[0] = 1'b0;
      step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) == 0,
           $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
           $urandom_range(4) < 2, a);
    end
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the fetch stage; successor to the combinational next-PC adder.
- Holds the PC and selects the next PC from increment, branch/jump and return.
- Adds a RUN/HALTED state machine, stall hold and a parametrised return-address stack (RAS) for call/return.
- Drives the instruction-memory address directly.

Parameters:
- INST_ADDR_WIDTH, 16, width of PC and all address ports.
- NUM_BYTES_IN_INST, 2, PC increment per instruction.
- RESET_VECTOR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).
- TRAP_VECTOR, 16'h0002, misalignment redirect target (used only with PC_ALIGN_CHECK_EN).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- halt  in  1  request entry to HALTED.
- resume  in  1  leave HALTED.
- stall  in  1  hold PC this cycle.
- pc_src  in  1  branch/jump taken; load branch_addr.
- call  in  1  taken jump to branch_addr plus push of return address.
- ret  in  1  return; pop RAS into PC.
- branch_addr  in  INST_ADDR_WIDTH  branch/call target.
- pc_out  out  INST_ADDR_WIDTH  current PC (registered).
- halted  out  1  high while in HALTED.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_overflow  out  1  sticky: a push occurred while full.
- ras_underflow  out  1  sticky: a pop occurred while empty.
- misalign  out  1  one-cycle pulse on a misaligned redirect (0 without the macro).

Behaviour:
- Reset (rst=0 at a clock edge) has priority over all other inputs, including mid-operation:
  - pc_out=RESET_VECTOR, state=RUN, halted=0.
  - RAS count=0, so ras_empty=1 and ras_full=0.
  - ras_overflow=0, ras_underflow=0, misalign=0.
- All outputs are registered. Inputs sampled at edge N take effect on pc_out after edge N, giving 1-cycle latency.
- States are RUN and HALTED; halted=1 exactly when state=HALTED.
- In RUN, the first matching rule applies:
  1. halt=1: go to HALTED, PC holds, RAS untouched.
  2. stall=1: PC holds, RAS untouched.
  3. call=1: push (pc_out+NUM_BYTES_IN_INST), PC=branch_addr. pc_src is don't-care, and a simultaneous ret is ignored.
  4. pc_src=1: PC=branch_addr; ret ignored.
  5. ret=1 and RAS not empty: PC=top entry, count decrements.
  6. ret=1 and RAS empty: PC=pc_out+NUM_BYTES_IN_INST, ras_underflow set to 1.
  7. Otherwise: PC=pc_out+NUM_BYTES_IN_INST.
- In HALTED:
  - PC and RAS hold; halt, stall, call, pc_src and ret are ignored.
  - resume=1 returns to RUN on the next edge; resume wins over a simultaneous halt.
  - The first increment happens on the edge after the one where RUN is entered.
  - resume in RUN has no effect.
- Arithmetic: increment is modulo 2^INST_ADDR_WIDTH, so all-ones minus 1 plus 2 wraps to 0 with no flag.
- RAS is circular, with a log2(RAS_DEPTH) pointer and a count saturating at RAS_DEPTH. A push when full:
  - overwrites the oldest entry;
  - sets ras_overflow to 1;
  - leaves count at RAS_DEPTH.
- ras_overflow and ras_underflow are cleared only by reset.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined: a redirect target (branch_addr for call/pc_src, or the popped entry for ret) with (target mod NUM_BYTES_IN_INST)!=0:
  - loads TRAP_VECTOR instead of the target;
  - pulses misalign=1 for one cycle;
  - for call, still pushes the return address; for ret, still pops.
- Undefined: targets are loaded unchanged and misalign is tied to 0.

Test Plan:
- Reset, then 3 free-run cycles -> pc_out 0, 2, 4, 6; ras_empty=1, halted=0.
- At pc_out=0x0010, call with branch_addr=0x0100, then 2 idle cycles, then ret -> 0x0100, 0x0102, 0x0104, 0x0012; ras_empty=1 afterwards.
- 5 calls with RAS_DEPTH=4, then 5 rets -> the 5th call sets ras_overflow. The first 4 rets return in LIFO order to the last 4 pushed addresses. The 5th ret increments PC and sets ras_underflow.
- At pc_out=0x0020, assert halt together with stall, then pulse resume 3 cycles later -> halted=1 and PC=0x0020 held throughout. After resume: 0x0020, then 0x0022.
- pc_out=0xFFFE, no control asserted -> next pc_out=0x0000. Asserting rst=0 during a HALTED cycle -> next pc_out=RESET_VECTOR, halted=0, flags cleared.
- With PC_ALIGN_CHECK_EN defined: pc_src with branch_addr=0x0101 -> pc_out=TRAP_VECTOR and a one-cycle misalign pulse. Without the macro: pc_out=0x0101, misalign=0.
